// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its command sequencer.
// Opcodes, data widths and the sequencer FSM state type live here.
package alu_pkg;

    localparam int unsigned ALU_W = 8;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND  = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [OP_W-1:0] ALU_SHL  = 3'b101;
    localparam logic [OP_W-1:0] ALU_SHR  = 3'b110;
    localparam logic [OP_W-1:0] ALU_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// Command sequencer in front of the ALU: registers operands for one EXEC cycle,
// captures result/flags and holds them on a valid/ready response port.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned W     = ALU_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic             cmd_chain,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_cin,
    input  logic [W-1:0]     alu_out,
    input  logic             alu_cout,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    seq_state_t      state_q, state_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic            alu_cin_q, alu_cin_d;
    logic            chain_q, chain_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic            accept;

    // Ready depends only on state and the consumer, never on cmd_valid.
    assign cmd_ready = (state_q == IDLE) | ((state_q == HOLD) & rsp_ready);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_cin_d  = alu_cin_q;
        chain_d    = chain_q;
        rsp_data_d = rsp_data_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        op_count_d = op_count_q;

        case (state_q)
            IDLE: ;
            EXEC: begin
                rsp_data_d = alu_out;
                carry_d    = alu_cout;
                zero_d     = chain_q ? (alu_zero & zero_q) : alu_zero;
                state_d    = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A command accepted in HOLD overrides the return to IDLE.
        if (accept) begin
            alu_a_d   = cmd_a;
            alu_b_d   = cmd_b;
            alu_op_d  = cmd_op;
            alu_cin_d = cmd_chain ? carry_q : cmd_op[0];
            chain_d   = cmd_chain;
            state_d   = EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_cin_q  <= 1'b0;
            chain_q    <= 1'b0;
            rsp_data_q <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_cin_q  <= alu_cin_d;
            chain_q    <= chain_d;
            rsp_data_q <= rsp_data_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            op_count_q <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = alu_cin_q;
    assign rsp_valid = (state_q == HOLD);
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an ALU stand-in drives the alu_* return path, vectors and
// random commands are checked against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [W-1:0]     cmd_a, cmd_b;
    logic             cmd_chain;
    logic [W-1:0]     alu_a, alu_b;
    logic [OP_W-1:0]  alu_op;
    logic             alu_cin;
    logic [W-1:0]     alu_out;
    logic             alu_cout;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;
    logic [CNT_W-1:0] op_count;

    alu_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU stand-in; SUB uses cin as the not-borrow input.
    logic [W:0] sum9;
    always_comb begin
        sum9     = '0;
        alu_out  = '0;
        alu_cout = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                {alu_cout, alu_out} = sum9;
            end
            ALU_SUB: begin
                sum9 = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
                {alu_cout, alu_out} = sum9;
            end
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            ALU_SHL: {alu_cout, alu_out} = {alu_a, 1'b0};
            ALU_SHR: {alu_out, alu_cout} = {1'b0, alu_a};
            default: alu_out = alu_a;
        endcase
        alu_zero = (alu_out == '0);
    end

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;
    bit ref_carry = 1'b0;
    bit ref_zero  = 1'b0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic       exp_cin;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_zero;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the command, tracking the stored flags.
    task automatic ref_exec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic chain, output logic [7:0] data, output logic cin,
                            output logic carry, output logic zero);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        cin   = chain ? ref_carry : op[0];
        carry = 1'b0;
        case (op)
            3'd0: begin r = ia + ib + int'(cin); carry = (r >= 256); end
            3'd1: begin r = ia - ib - (cin ? 0 : 1); carry = (r >= 0); end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: begin r = ia * 2; carry = (ia >= 128); end
            3'd6: begin r = ia / 2; carry = (ia % 2 == 1); end
            default: r = ia;
        endcase
        data = 8'((r + 512) % 256);
        zero = chain ? ((data == 0) && ref_zero) : (data == 0);
        ref_carry = carry;
        ref_zero  = zero;
    endtask

    // Present a command and return just after the edge that accepts it.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic chain);
        int n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_wait", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % 16;
        check("op_count", op_count, exp_count);
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    logic [7:0] e_data;
    logic       e_cin, e_carry, e_zero;

    initial begin
        vecs[0] = '{3'd0, 8'd95,  8'd14,  1'b0, 1'b0, 8'd109, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 8'hFF,  8'h01,  1'b0, 1'b0, 8'h00,  1'b1, 1'b1};
        vecs[2] = '{3'd0, 8'h01,  8'h00,  1'b1, 1'b1, 8'h02,  1'b0, 1'b0};
        vecs[3] = '{3'd1, 8'd95,  8'd14,  1'b0, 1'b1, 8'd81,  1'b1, 1'b0};
        vecs[4] = '{3'd1, 8'h10,  8'h10,  1'b1, 1'b1, 8'h00,  1'b1, 1'b0};
        vecs[5] = '{3'd0, 8'h00,  8'h00,  1'b0, 1'b0, 8'h00,  1'b0, 1'b1};
        vecs[6] = '{3'd0, 8'h00,  8'h00,  1'b1, 1'b0, 8'h00,  1'b0, 1'b1};
        vecs[7] = '{3'd2, 8'hF0,  8'h0F,  1'b0, 1'b0, 8'h00,  1'b0, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_op_count", op_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_cin", alu_cin, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_flags", {rsp_carry, rsp_zero}, 0);

        // Directed vectors with exact latency checks.
        for (int i = 0; i < 8; i++) begin
            ref_exec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain,
                     e_data, e_cin, e_carry, e_zero);
            cmd_op = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
            cmd_chain = vecs[i].chain; cmd_valid = 1'b1;
            #1;
            check("vec_cmd_ready", cmd_ready, 1);
            tick();
            cmd_valid = 1'b0;
            check("vec_exec_no_valid", rsp_valid, 0);
            check("vec_alu_a", alu_a, vecs[i].a);
            check("vec_alu_b", alu_b, vecs[i].b);
            check("vec_alu_op", alu_op, vecs[i].op);
            check("vec_alu_cin", alu_cin, vecs[i].exp_cin);
            tick();
            check("vec_rsp_valid", rsp_valid, 1);
            check("vec_rsp_data", rsp_data, vecs[i].exp_data);
            check("vec_rsp_carry", rsp_carry, vecs[i].exp_carry);
            check("vec_rsp_zero", rsp_zero, vecs[i].exp_zero);
            check("vec_hold_not_ready", cmd_ready, 0);
            rsp_ready = 1'b1;
            #1;
            check("vec_ready_when_consumed", cmd_ready, 1);
            rsp_ready = 1'b0;
            consume();
        end

        // Backpressure then a same-cycle handshake plus accept.
        ref_exec(3'd0, 8'd200, 8'd100, 1'b0, e_data, e_cin, e_carry, e_zero);
        issue(3'd0, 8'd200, 8'd100, 1'b0);
        tick();
        check("bp_first_data", rsp_data, 44);
        check("bp_first_carry", rsp_carry, 1);
        ref_exec(3'd0, 8'd3, 8'd4, 1'b1, e_data, e_cin, e_carry, e_zero);
        cmd_op = 3'd0; cmd_a = 8'd3; cmd_b = 8'd4; cmd_chain = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_cmd_ready_low", cmd_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 44);
            check("bp_rsp_carry", rsp_carry, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", cmd_ready, 1);
        tick();
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        exp_count = (exp_count + 1) % 16;
        check("bp_op_count", op_count, exp_count);
        check("bp_valid_gap", rsp_valid, 0);
        check("bp_chain_cin", alu_cin, e_cin);
        tick();
        check("bp_second_valid", rsp_valid, 1);
        check("bp_second_data", rsp_data, 8);
        check("bp_second_carry", rsp_carry, 0);
        consume();

        // Randomised commands with random response stalls.
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [7:0] a  = 8'($urandom);
            logic [7:0] b  = 8'($urandom);
            logic       ch = 1'($urandom_range(0, 1));
            int stall = $urandom_range(0, 3);
            ref_exec(op, a, b, ch, e_data, e_cin, e_carry, e_zero);
            issue(op, a, b, ch);
            check("rnd_alu_cin", alu_cin, e_cin);
            tick();
            check("rnd_latency", rsp_valid, 1);
            for (int s = 0; s <= stall; s++) begin
                check("rnd_data", rsp_data, e_data);
                check("rnd_flags", {rsp_carry, rsp_zero}, {e_carry, e_zero});
                if (s < stall) tick();
            end
            consume();
        end

        // Reset while a command is in EXEC.
        ref_exec(3'd0, 8'hFF, 8'h01, 1'b0, e_data, e_cin, e_carry, e_zero);
        issue(3'd0, 8'hFF, 8'h01, 1'b0);
        tick();
        check("pre_rst_carry", rsp_carry, 1);
        consume();
        issue(3'd0, 8'hFF, 8'h02, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_carry = 1'b0; ref_zero = 1'b0; exp_count = 0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_flags", {rsp_carry, rsp_zero}, 0);
        tick();
        check("mid_rst_stays_idle", rsp_valid, 0);
        ref_exec(3'd0, 8'd5, 8'd6, 1'b1, e_data, e_cin, e_carry, e_zero);
        issue(3'd0, 8'd5, 8'd6, 1'b1);
        check("post_rst_chain_cin", alu_cin, 0);
        tick();
        check("post_rst_data", rsp_data, 11);
        check("post_rst_zero", rsp_zero, 0);
        consume();

        // Fifteen more handshakes wrap the 4-bit counter back to zero.
        for (int i = 0; i < 15; i++) begin
            issue(3'd7, 8'(i), 8'd0, 1'b0);
            tick();
            consume();
        end
        check("wrap_zero", op_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Command sequencer directly upstream of the 8-bit `alu`. It accepts operation commands over a valid/ready handshake and drives registered, stable operands into the ALU. It captures the ALU result and flags into output registers and presents them over a valid/ready response interface. Carry and zero flags persist between commands, so multi-byte add/subtract can be chained.

Parameters:
W, 8, operand/result width; must match the ALU data width
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  3  ALU opcode
cmd_a  input  W  operand A
cmd_b  input  W  operand B
cmd_chain  input  1  1: cin taken from stored carry flag, zero flag accumulates
alu_a  output  W  to ALU A
alu_b  output  W  to ALU B
alu_op  output  3  to ALU op
alu_cin  output  1  to ALU cin
alu_out  input  W  from ALU out
alu_cout  input  1  from ALU cout
alu_zero  input  1  from ALU zero
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes the result
rsp_data  output  W  captured result
rsp_carry  output  1  captured carry flag
rsp_zero  output  1  captured zero flag (accumulated when chained)
op_count  output  CNT_W  number of responses consumed

Behaviour:
- Reset values: all of the following clear to 0, and the FSM goes to IDLE. This applies mid-operation too, and any in-flight command is discarded.
  - Outputs: alu_a, alu_b, alu_op, alu_cin, rsp_data, rsp_carry, rsp_zero, rsp_valid, op_count.
  - Internal registers: carry_q, zero_q.
- FSM states:
  - IDLE: cmd_ready=1.
  - EXEC: ALU inputs held stable for exactly one cycle.
  - HOLD: rsp_valid=1.
- cmd_ready = (state==IDLE) | (state==HOLD & rsp_ready). This is combinational; there is no combinational path from cmd_valid to cmd_ready.
- Accept (cmd_valid & cmd_ready) at edge k:
  - alu_a/alu_b/alu_op register cmd_a/cmd_b/cmd_op.
  - alu_cin registers carry_q if cmd_chain, else cmd_op[0].
  - The chain bit is latched.
  - State becomes EXEC.
- EXEC, edge k+1: capture the ALU outputs and go to HOLD.
  - rsp_data=alu_out.
  - rsp_carry=carry_q=alu_cout.
  - rsp_zero=zero_q = chain ? (alu_zero & zero_q) : alu_zero.
- Latency: rsp_valid rises 2 cycles after accept. rsp_* are stable while rsp_valid & !rsp_ready.
- HOLD, rsp_ready=1:
  - op_count increments; it wraps to 0 after 2^CNT_W-1.
  - If cmd_valid is also high, the new command is accepted in the same cycle and the next state is EXEC. rsp_valid drops for that one cycle, giving back-to-back throughput of 1 result per 2 cycles.
  - Otherwise the next state is IDLE and rsp_valid drops.
- HOLD, rsp_ready=0: stay in HOLD; cmd_ready=0.
- alu_* outputs keep their last value outside EXEC.
- A chained command right after reset uses carry_q=0 and zero_q=0. The first byte of a chain must therefore use cmd_chain=0.

Decomposition:
- Shared package `alu_pkg`:
  - Parameter defaults W=8 and OP_W=3.
  - Opcode constants: ALU_ADD=3'b000, ALU_SUB=3'b001, remaining ALU opcodes.
  - FSM state enum {IDLE, EXEC, HOLD}.
- No sub-module. The op counter is inline. The `alu` instance lives in the parent, not inside alu_seq.

Test Plan:
- Basic ADD: A=95, B=14, op=000, chain=0, rsp_ready=1 → 2 cycles after accept, rsp_valid=1, rsp_data=109, rsp_carry=0, rsp_zero=0; op_count=1 after the handshake.
- Chained 16-bit add, 0x01FF+0x0001:
  - Command 1: low bytes 0xFF+0x01, chain=0 → rsp_data=0x00, carry=1, zero=1.
  - Command 2: high bytes 0x01+0x00, chain=1 → alu_cin=1, rsp_data=0x02, carry=0, zero=0.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready=0 throughout and rsp_* unchanged. Raising rsp_ready accepts the next command in the same cycle, and rsp_valid returns 2 cycles later.
- SUB with cin rule: A=95, B=14, op=001, chain=0 → alu_cin=1, rsp_data=81, rsp_carry=1.
- Reset mid-operation: assert rst during EXEC → the next cycle shows rsp_valid=0, state IDLE, cmd_ready=1, op_count=0, carry/zero cleared. A following chained command sees alu_cin=0.
- Counter wrap: CNT_W=4, complete 16 handshakes → op_count returns to 0.
